// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake, flush and optional skid entry
// SKID=1 gives a registered in_ready via a second entry; SKID=0 is a single entry with combinational in_ready.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SKID        = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Encoding is {skid_valid, out_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    generate
        if (SKID) begin : g_skid
            state_t           r_state;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic             r_in_ready;
            logic             r_out_valid;
            logic             w_tin;
            logic             w_tout;

            assign w_tin  = in_valid & r_in_ready;
            assign w_tout = r_out_valid & out_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state     <= ST_EMPTY;
                    r_main      <= RESET_VALUE;
                    r_skid      <= RESET_VALUE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end else if (flush) begin
                    r_state     <= ST_EMPTY;
                    r_main      <= RESET_VALUE;
                    r_skid      <= RESET_VALUE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_tin) begin
                                r_main      <= in_data;
                                r_out_valid <= 1'b1;
                                r_state     <= ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            if (w_tin && w_tout) begin
                                r_main <= in_data;
                            end else if (w_tin) begin
                                r_skid     <= in_data;
                                r_in_ready <= 1'b0;
                                r_state    <= ST_SKID;
                            end else if (w_tout) begin
                                r_out_valid <= 1'b0;
                                r_state     <= ST_EMPTY;
                            end
                        end
                        ST_SKID: begin
                            // in_ready is low here, so only the drain path can fire
                            if (w_tout) begin
                                r_main     <= r_skid;
                                r_in_ready <= 1'b1;
                                r_state    <= ST_FULL;
                            end
                        end
                        default: begin
                            r_state     <= ST_EMPTY;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                        end
                    endcase
                end
            end

            assign in_ready  = r_in_ready;
            assign out_valid = r_out_valid;
            assign out_data  = r_main;
        end else begin : g_single
            logic [WIDTH-1:0] r_main;
            logic             r_out_valid;
            logic             w_in_ready;
            logic             w_tin;

            assign w_in_ready = ~r_out_valid | out_ready;
            assign w_tin      = in_valid & w_in_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_main      <= RESET_VALUE;
                    r_out_valid <= 1'b0;
                end else if (flush) begin
                    r_main      <= RESET_VALUE;
                    r_out_valid <= 1'b0;
                end else if (w_tin) begin
                    r_main      <= in_data;
                    r_out_valid <= 1'b1;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end

            assign in_ready  = w_in_ready;
            assign out_valid = r_out_valid;
            assign out_data  = r_main;
        end
    endgenerate

endmodule
